// File: rtl/ndro_bank_scheduler.sv
// ---------------------------------------------------------------------------
// ndro_bank_scheduler
//   Issues toggle-encoded set/reset/clk pulses into a bank of NDRO cells on
//   behalf of one write requester and one read requester. At most one pulse
//   leaves the block per cycle. A round-robin pointer arbitrates when both
//   requesters are eligible. Per-cell hold-off timers keep reset->set and
//   clk->clk pulses to the same cell outside the cell's critical window.
//   A read issues a clk pulse, then recovers the stored bit from whether the
//   cell output toggled while the read was outstanding.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wr_valid/wr_ready   write handshake; ready is the combinational grant
//   wr_addr, wr_data    target cell; 1 issues a set pulse, 0 a reset pulse
//   rd_valid/rd_ready   read handshake; ready is the combinational grant
//   rd_addr             target cell of the read
//   rd_rsp_valid/data   one-cycle read response and recovered bit
//   cell_set/reset/clk  toggle-encoded pulse buses, one bit per cell
//   cell_out            cell outputs, one pulse per edge
//   busy                a read is outstanding (WAIT or RESP)
//   err_unexp           sticky flag for unexpected cell_out edges
// ---------------------------------------------------------------------------
module ndro_bank_scheduler #(
    parameter int N_CELLS  = 8,
    parameter int AW       = 3,
    parameter int GAP_RS   = 2,
    parameter int GAP_CLK  = 4,
    parameter int READ_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AW-1:0]      wr_addr,
    input  logic               wr_data,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [AW-1:0]      rd_addr,
    output logic               rd_rsp_valid,
    output logic               rd_rsp_data,
    output logic [N_CELLS-1:0] cell_set,
    output logic [N_CELLS-1:0] cell_reset,
    output logic [N_CELLS-1:0] cell_clk,
    input  logic [N_CELLS-1:0] cell_out,
    output logic               busy,
    output logic               err_unexp
);

    localparam int RSW = $clog2(GAP_RS + 1);
    localparam int CKW = $clog2(GAP_CLK + 1);
    localparam int LW  = $clog2(READ_LAT + 1);

    localparam logic [RSW-1:0] RS_LOAD  = RSW'(GAP_RS - 1);
    localparam logic [CKW-1:0] CLK_LOAD = CKW'(GAP_CLK - 1);
    localparam logic [LW-1:0]  LAT_LOAD = LW'(READ_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } rd_state_t;

    rd_state_t          state, state_nxt;
    logic [LW-1:0]      lat_cnt, lat_cnt_nxt;
    logic [AW-1:0]      rd_addr_q;
    logic               snap;
    logic               prio_wr;
    logic               armed;
    logic               seen_edge;
    logic [N_CELLS-1:0] out_q;
    logic [RSW-1:0]     rs_timer  [N_CELLS];
    logic [CKW-1:0]     clk_timer [N_CELLS];

    logic               wr_elig, rd_elig;
    logic               wr_grant, rd_grant;
    logic [N_CELLS-1:0] edges, wait_mask;
    logic               err_hit;

    assign busy = (state != S_IDLE);

    // Eligibility and arbitration. A set pulse waits out the reset->set
    // window; a reset pulse never waits. A lone eligible port always wins.
    assign wr_elig = wr_valid && !(busy && (rd_addr_q == wr_addr))
                   && (!wr_data || (rs_timer[wr_addr] == '0));
    assign rd_elig = rd_valid && !busy && (clk_timer[rd_addr] == '0);

    assign wr_grant = !reset && wr_elig && (prio_wr || !rd_elig);
    assign rd_grant = !reset && rd_elig && (!prio_wr || !wr_elig);
    assign wr_ready = wr_grant;
    assign rd_ready = rd_grant;

    assign rd_rsp_valid = (state == S_RESP);
    assign rd_rsp_data  = (state == S_RESP) && (cell_out[rd_addr_q] ^ snap);

    // Edge detection on cell_out. Only the cell under read, while in WAIT,
    // may toggle, and only once. `armed` suppresses the first comparison
    // after reset, when out_q has not yet captured the live outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        wait_mask = '0;
        if (state == S_WAIT) wait_mask[rd_addr_q] = 1'b1;
        edges   = armed ? (cell_out ^ out_q) : '0;
        err_hit = (|(edges & ~wait_mask)) || ((|(edges & wait_mask)) && seen_edge);
    end

    // Read FSM next state. The counter is loaded with READ_LAT and WAIT
    // leaves when it would reach zero, giving READ_LAT+1 cycles from the
    // grant to the RESP cycle.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        case (state)
            S_IDLE: begin
                if (rd_grant) begin
                    state_nxt   = S_WAIT;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LW'(1)) begin
                    state_nxt   = S_RESP;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_set   <= '0;
            cell_reset <= '0;
            cell_clk   <= '0;
            rd_addr_q  <= '0;
            snap       <= 1'b0;
            prio_wr    <= 1'b1;
            armed      <= 1'b0;
            seen_edge  <= 1'b0;
            out_q      <= '0;
            err_unexp  <= 1'b0;
            // NOTE: the timer arrays are flops, not RAM, and must clear on reset so the bank starts unblocked.
            for (int i = 0; i < N_CELLS; i++) begin
                rs_timer[i]  <= '0;
                clk_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CELLS; i++) begin
                if (rs_timer[i] != '0)  rs_timer[i]  <= rs_timer[i] - 1'b1;
                if (clk_timer[i] != '0) clk_timer[i] <= clk_timer[i] - 1'b1;
            end

            // A fresh load below overrides the decrement of the same cell.
            if (wr_grant) begin
                if (wr_data) begin
                    cell_set[wr_addr] <= ~cell_set[wr_addr];
                end else begin
                    cell_reset[wr_addr] <= ~cell_reset[wr_addr];
                    rs_timer[wr_addr]   <= RS_LOAD;
                end
            end

            if (rd_grant) begin
                cell_clk[rd_addr]  <= ~cell_clk[rd_addr];
                clk_timer[rd_addr] <= CLK_LOAD;
                rd_addr_q          <= rd_addr;
                snap               <= cell_out[rd_addr];
            end

            // Priority passes to the port that did not just win.
            if (wr_grant || rd_grant) prio_wr <= rd_grant;

            armed <= 1'b1;
            out_q <= cell_out;
            if (rd_grant)                seen_edge <= 1'b0;
            else if (|(edges & wait_mask)) seen_edge <= 1'b1;
            if (err_hit) err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ndro_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ndro_bank_scheduler
//   Self-checking bench for ndro_bank_scheduler (default parameters).
//   A small NDRO bank model reacts to the pulse buses and toggles cell_out
//   when a clocked cell holds a 1. Read responses are predicted at grant
//   time and queued; a monitor pops and compares them as they appear.
// ---------------------------------------------------------------------------
module tb_ndro_bank_scheduler;

    localparam int N        = 8;
    localparam int READ_LAT = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_valid = 1'b0, wr_data = 1'b0, rd_valid = 1'b0;
    logic [2:0]   wr_addr = '0, rd_addr = '0;
    logic         wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data, busy, err_unexp;
    logic [N-1:0] cell_set, cell_reset, cell_clk, cell_out;
    logic [N-1:0] cell_out_m = '0;
    logic [N-1:0] inj = '0;
    logic [N-1:0] stored = '0;
    logic [N-1:0] prev_set = '0, prev_rst = '0, prev_clk = '0;
    logic [N-1:0] sh_set = '0, sh_rst = '0, sh_clk = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        logic data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic       wv;
        logic [2:0] wa;
        logic       wd;
        logic       rv;
        logic [2:0] ra;
        logic       ew;
        logic       er;
        logic       eb;
    } vec_t;
    vec_t vt[18];

    assign cell_out = cell_out_m ^ inj;

    ndro_bank_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .cell_set     (cell_set),
        .cell_reset   (cell_reset),
        .cell_clk     (cell_clk),
        .cell_out     (cell_out),
        .busy         (busy),
        .err_unexp    (err_unexp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int wv, input int wa, input int wd, input int rv,
                                input int ra, input int ew, input int er, input int eb);
        vec_t v;
        v.wv = wv[0]; v.wa = wa[2:0]; v.wd = wd[0];
        v.rv = rv[0]; v.ra = ra[2:0];
        v.ew = ew[0]; v.er = er[0]; v.eb = eb[0];
        return v;
    endfunction

    // Expected response: the bit the cell model holds when the clk pulse is issued.
    task automatic expect_rsp(input logic [2:0] a);
        rsp_t e;
        e.cyc  = cyc + READ_LAT + 1;
        e.data = stored[a];
        sb.push_back(e);
    endtask

    task automatic drive(input logic wv, input logic [2:0] wa, input logic wd,
                         input logic rv, input logic [2:0] ra);
        @(negedge clk);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_valid = 1'b1; rd_valid = 1'b1;
        sb.delete();
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rd_rsp_valid, 0);
        check("rst_err", err_unexp, 0);
        check("rst_buses", int'(|{cell_set, cell_reset, cell_clk}), 0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        sh_set = '0; sh_rst = '0; sh_clk = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    // NDRO bank model: each bus edge is one pulse; a clk pulse into a cell
    // holding 1 makes its output toggle shortly after.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_set = cell_set; prev_rst = cell_reset; prev_clk = cell_clk;
        end else begin
            check("one_pulse_per_cycle",
                  $countones({cell_set ^ prev_set, cell_reset ^ prev_rst, cell_clk ^ prev_clk}) <= 1, 1);
            for (int i = 0; i < N; i++) begin
                if (cell_set[i] != prev_set[i]) stored[i] = 1'b1;
                if (cell_reset[i] != prev_rst[i]) stored[i] = 1'b0;
                if (cell_clk[i] != prev_clk[i] && stored[i]) cell_out_m[i] = ~cell_out_m[i];
            end
            prev_set = cell_set; prev_rst = cell_reset; prev_clk = cell_clk;
        end
    end

    // Response monitor: compare each strobe with the oldest prediction.
    always @(negedge clk) begin
        rsp_t e;
        #2;
        if (!reset) begin
            if (rd_rsp_valid) begin
                check("rsp_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rsp_cycle", cyc, e.cyc);
                    check("rsp_data", rd_rsp_data, e.data);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                check("rsp_latency", cyc + 1, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // wv wa wd rv ra | ew er eb
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 3, 1, 0, 0, 1, 0, 0);  // set cell 3
        vt[2]  = mk(0, 0, 0, 1, 3, 0, 1, 0);  // read cell 3 -> 1
        vt[3]  = mk(1, 5, 0, 0, 0, 1, 0, 1);  // reset cell 5 during WAIT
        vt[4]  = mk(1, 5, 1, 0, 0, 0, 0, 1);  // set held off one cycle
        vt[5]  = mk(1, 5, 1, 0, 0, 1, 0, 1);  // set at t+2
        vt[6]  = mk(1, 3, 0, 0, 0, 0, 0, 1);  // pending cell 3 in RESP: stall
        vt[7]  = mk(1, 3, 0, 1, 2, 0, 1, 0);  // both eligible, pointer at rd
        vt[8]  = mk(1, 3, 0, 1, 2, 1, 0, 1);  // write other cell during WAIT
        vt[9]  = mk(1, 2, 1, 1, 2, 0, 0, 1);  // write to read-pending cell stalls
        vt[10] = mk(1, 2, 1, 1, 2, 0, 0, 1);
        vt[11] = mk(1, 2, 1, 1, 2, 0, 0, 1);  // RESP: both stall
        vt[12] = mk(1, 2, 1, 1, 2, 0, 1, 0);  // second read at t+5, wins RR
        vt[13] = mk(1, 2, 1, 0, 0, 0, 0, 1);
        vt[14] = mk(1, 2, 1, 0, 0, 0, 0, 1);
        vt[15] = mk(1, 2, 1, 0, 0, 0, 0, 1);
        vt[16] = mk(1, 2, 1, 0, 0, 0, 0, 1);
        vt[17] = mk(1, 2, 1, 0, 0, 1, 0, 0);  // write finally issues

        // T1: reset while a read is in WAIT drops it without a response.
        do_reset();
        idle(1);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd4);
        check("t1_rd_ready", rd_ready, 1);
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("t1_busy_wait", busy, 1);
        reset = 1'b1;
        #1;
        check("t1_busy", busy, 0);
        check("t1_err", err_unexp, 0);
        check("t1_buses", int'(|{cell_set, cell_reset, cell_clk}), 0);
        check("t1_rsp_valid", rd_rsp_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(8);
        check("t1_busy_after", busy, 0);

        // Table: T2, T3, T4 and same-cell RR corner.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].wv, vt[i].wa, vt[i].wd, vt[i].rv, vt[i].ra);
            check($sformatf("v%0d_wr_ready", i), wr_ready, vt[i].ew);
            check($sformatf("v%0d_rd_ready", i), rd_ready, vt[i].er);
            check($sformatf("v%0d_busy", i), busy, vt[i].eb);
            check($sformatf("v%0d_cell_set", i), cell_set, sh_set);
            check($sformatf("v%0d_cell_reset", i), cell_reset, sh_rst);
            check($sformatf("v%0d_cell_clk", i), cell_clk, sh_clk);
            if (vt[i].er) begin
                expect_rsp(vt[i].ra);
                sh_clk[vt[i].ra] = ~sh_clk[vt[i].ra];
            end
            if (vt[i].ew) begin
                if (vt[i].wd) sh_set[vt[i].wa] = ~sh_set[vt[i].wa];
                else          sh_rst[vt[i].wa] = ~sh_rst[vt[i].wa];
            end
        end
        idle(1);
        check("tbl_cell_set", cell_set, sh_set);
        check("tbl_cell_reset", cell_reset, sh_rst);
        check("tbl_cell_clk", cell_clk, sh_clk);
        drain();
        check("tbl_err", err_unexp, 0);

        // T5: both ports hammering cells 1 and 6; a read wins every 5th cycle.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 3'd1, 1'b1, 1'b1, 3'd6);
            check($sformatf("t5_c%0d_rd_ready", c), rd_ready, int'(c % 5 == 1));
            check($sformatf("t5_c%0d_wr_ready", c), wr_ready, int'(c % 5 != 1));
            if (c % 5 == 1) expect_rsp(3'd6);
        end
        idle(1);
        drain();
        check("t5_err", err_unexp, 0);

        // Second edge on the read cell within one WAIT.
        do_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd0);
        check("dbl_rd_ready", rd_ready, 1);
        expect_rsp(3'd0);
        @(negedge clk);
        rd_valid = 1'b0;
        inj[0] = ~inj[0];
        @(negedge clk);
        inj[0] = ~inj[0];
        @(negedge clk);
        #1;
        check("dbl_err", err_unexp, 1);
        drain();

        // T6: stray edge on cell 7 with no read pending; sticky until reset.
        do_reset();
        idle(2);
        check("t6_err_before", err_unexp, 0);
        @(negedge clk);
        inj[7] = ~inj[7];
        @(negedge clk);
        #1;
        check("t6_err_next", err_unexp, 1);
        idle(5);
        check("t6_err_sticky", err_unexp, 1);
        do_reset();
        idle(3);
        check("t6_err_cleared", err_unexp, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
